// File: rtl/timer_prescaler.sv
// Synchronous timer prescaler: emits a one-pclk count-enable tick every 2^(k+1) cycles.
// A new divide select waits until a period boundary, or is taken at once while disabled.
module timer_prescaler #(
   parameter int SEL_W   = 3,
   parameter int MAX_SEL = 7
) (
   input  logic             pclk,
   input  logic             preset_n,
   input  logic             en,
   input  logic             halt,
   input  logic [SEL_W-1:0] cks,
   input  logic             cks_upd,
   output logic             tick,
   output logic [SEL_W-1:0] cks_active,
   output logic             sel_pend
);

   localparam int CNT_W = MAX_SEL + 1;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period_mask;
   logic [SEL_W-1:0] pend_val;
   logic [SEL_W-1:0] cks_clamped;
   logic [SEL_W-1:0] next_sel;
   logic             boundary;
   logic             apply_req;

   always_comb begin
      cks_clamped = cks;
      if (int'(cks) > MAX_SEL)
         cks_clamped = SEL_W'(MAX_SEL);
      next_sel  = cks_upd ? cks_clamped : pend_val;
      apply_req = sel_pend | cks_upd;
   end

   // Low cks_active+1 bits of the counter decide the boundary; upper bits stay 0.
   always_comb begin
      period_mask = '0;
      for (int i = 0; i < CNT_W; i++)
         period_mask[i] = (i <= int'(cks_active));
      boundary = ((cnt & period_mask) == period_mask);
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         cnt        <= '0;
         tick       <= 1'b0;
         cks_active <= '0;
         pend_val   <= '0;
         sel_pend   <= 1'b0;
      end else if (!en) begin
         cnt  <= '0;
         tick <= 1'b0;
         if (apply_req) begin
            cks_active <= next_sel;
            pend_val   <= next_sel;
            sel_pend   <= 1'b0;
         end
      end else if (halt) begin
         // Counter frozen; a strobe is still captured but never applied here.
         tick <= 1'b0;
         if (cks_upd) begin
            pend_val <= cks_clamped;
            sel_pend <= 1'b1;
         end
      end else if (boundary) begin
         tick <= 1'b1;
         cnt  <= '0;
         if (apply_req) begin
            cks_active <= next_sel;
            pend_val   <= next_sel;
            sel_pend   <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
         cnt  <= cnt + CNT_W'(1);
         if (cks_upd) begin
            pend_val <= cks_clamped;
            sel_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_timer_prescaler.sv
// Bench for timer_prescaler: two instances (3-bit/max 7 and 4-bit/max 5) share stimulus
// and are compared every cycle against an elapsed-cycle model, plus directed checks.
module tb_timer_prescaler;

   logic       pclk = 1'b0;
   logic       preset_n;
   logic       en;
   logic       halt;
   logic [3:0] cks;
   logic       cks_upd;
   logic       tick0, tick5;
   logic [2:0] act0;
   logic [3:0] act5;
   logic       pend0, pend5;

   int vectors = 0;
   int miscompares = 0;

   always #5 pclk = ~pclk;

   timer_prescaler u_dut (
      .pclk(pclk), .preset_n(preset_n), .en(en), .halt(halt), .cks(cks[2:0]),
      .cks_upd(cks_upd), .tick(tick0), .cks_active(act0), .sel_pend(pend0)
   );

   timer_prescaler #(.SEL_W(4), .MAX_SEL(5)) u_dut5 (
      .pclk(pclk), .preset_n(preset_n), .en(en), .halt(halt), .cks(cks),
      .cks_upd(cks_upd), .tick(tick5), .cks_active(act5), .sel_pend(pend5)
   );

   // Reference model: m_el counts counting edges in the current period.
   int max_sel[2] = '{7, 5};
   int sel_lim[2] = '{7, 15};
   int m_act[2], m_pend[2], m_pval[2], m_el[2], m_tick[2];

   function automatic int clamp_sel(int i, int v);
      int s;
      s = v & sel_lim[i];
      return (s > max_sel[i]) ? max_sel[i] : s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 0; m_pend[i] = 0; m_pval[i] = 0; m_el[i] = 0; m_tick[i] = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         int nxt;
         nxt = cks_upd ? clamp_sel(i, int'(cks)) : m_pval[i];
         if (!en) begin
            m_el[i] = 0; m_tick[i] = 0;
            if (m_pend[i] != 0 || cks_upd) begin
               m_act[i] = nxt; m_pval[i] = nxt; m_pend[i] = 0;
            end
         end else if (halt) begin
            m_tick[i] = 0;
            if (cks_upd) begin m_pval[i] = nxt; m_pend[i] = 1; end
         end else begin
            m_el[i] = m_el[i] + 1;
            if (m_el[i] == (1 << (m_act[i] + 1))) begin
               m_tick[i] = 1; m_el[i] = 0;
               if (m_pend[i] != 0 || cks_upd) begin
                  m_act[i] = nxt; m_pval[i] = nxt; m_pend[i] = 0;
               end
            end else begin
               m_tick[i] = 0;
               if (cks_upd) begin m_pval[i] = nxt; m_pend[i] = 1; end
            end
         end
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("tick0", int'(tick0), m_tick[0]);
      check("cks_active0", int'(act0), m_act[0]);
      check("sel_pend0", int'(pend0), m_pend[0]);
      check("tick5", int'(tick5), m_tick[1]);
      check("cks_active5", int'(act5), m_act[1]);
      check("sel_pend5", int'(pend5), m_pend[1]);
   endtask

   // Inputs are set at the falling edge before calling this.
   task automatic cycle();
      @(posedge pclk);
      model_step();
      @(negedge pclk);
      compare_all();
   endtask

   task automatic set_in(input logic e, input logic h, input int k, input logic u);
      en = e; halt = h; cks = 4'(k); cks_upd = u;
   endtask

   // Apply a select while disabled (takes effect on the next edge).
   task automatic load_sel(input int k);
      set_in(1'b0, 1'b0, k, 1'b1);
      cycle();
      set_in(1'b0, 1'b0, 0, 1'b0);
   endtask

   int n, ticks, found;

   initial begin
      model_reset();
      preset_n = 1'b0;
      set_in(1'b0, 1'b0, 0, 1'b0);
      repeat (2) @(negedge pclk);
      check("reset_tick", int'(tick0), 0);
      check("reset_act", int'(act0), 0);
      check("reset_pend", int'(pend0), 0);
      compare_all();
      preset_n = 1'b1;

      // 1: /2 free running -> 16 ticks in 32 cycles
      set_in(1'b1, 1'b0, 0, 1'b0);
      ticks = 0;
      for (int i = 0; i < 32; i++) begin cycle(); ticks += int'(tick0); end
      check("t1_ticks", ticks, 16);

      // 2: /8, strobe cks=0 three cycles into the period
      load_sel(2);
      check("t2_act", int'(act0), 2);
      set_in(1'b1, 1'b0, 0, 1'b0);
      repeat (3) cycle();
      set_in(1'b1, 1'b0, 0, 1'b1);
      cycle();
      check("t2_pend", int'(pend0), 1);
      set_in(1'b1, 1'b0, 0, 1'b0);
      n = 1; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(); n++;
         if (tick0) found = 1;
         else check("t2_pend_hold", int'(pend0), 1);
      end
      check("t2_tick_delay", n, 5);
      check("t2_act_after", int'(act0), 0);
      cycle();
      check("t2_gap_mid", int'(tick0), 0);
      cycle();
      check("t2_gap_tick", int'(tick0), 1);

      // 3: clamp on the 4-bit instance, /64 period
      load_sel(9);
      check("t3_act5", int'(act5), 5);
      check("t3_pend5", int'(pend5), 0);
      set_in(1'b1, 1'b0, 0, 1'b0);
      n = 0; found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         cycle(); n++;
         if (tick5) found = 1;
      end
      check("t3_first_tick", n, 64);
      ticks = 0;
      for (int i = 0; i < 128; i++) begin cycle(); ticks += int'(tick5); end
      check("t3_ticks128", ticks, 2);

      // 4: /8, halt 5 cycles at cnt=3
      load_sel(2);
      set_in(1'b1, 1'b0, 0, 1'b0);
      repeat (3) cycle();
      set_in(1'b1, 1'b1, 0, 1'b0);
      ticks = 0;
      for (int i = 0; i < 5; i++) begin cycle(); ticks += int'(tick0); end
      check("t4_halt_ticks", ticks, 0);
      set_in(1'b1, 1'b0, 0, 1'b0);
      n = 5; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(); n++;
         if (tick0) found = 1;
      end
      check("t4_tick_delay", n, 10);

      // 5: /4, disable at cnt=2 for 3 cycles
      load_sel(1);
      set_in(1'b1, 1'b0, 0, 1'b0);
      repeat (2) cycle();
      set_in(1'b0, 1'b0, 0, 1'b0);
      ticks = 0;
      for (int i = 0; i < 3; i++) begin cycle(); ticks += int'(tick0); end
      check("t5_off_ticks", ticks, 0);
      set_in(1'b1, 1'b0, 0, 1'b0);
      n = 0; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(); n++;
         if (tick0) found = 1;
      end
      check("t5_tick_delay", n, 4);

      // 6: /16 with a pending select, then async reset mid-period
      load_sel(3);
      set_in(1'b1, 1'b0, 0, 1'b0);
      repeat (5) cycle();
      set_in(1'b1, 1'b0, 0, 1'b1);
      cycle();
      check("t6_pend", int'(pend0), 1);
      set_in(1'b1, 1'b0, 0, 1'b0);
      #2 preset_n = 1'b0;
      #1;
      check("t6_rst_tick", int'(tick0), 0);
      check("t6_rst_act", int'(act0), 0);
      check("t6_rst_pend", int'(pend0), 0);
      check("t6_rst_act5", int'(act5), 0);
      model_reset();
      @(posedge pclk);
      @(negedge pclk);
      compare_all();
      preset_n = 1'b1;
      ticks = 0;
      for (int i = 0; i < 8; i++) begin cycle(); ticks += int'(tick0); end
      check("t6_resume_ticks", ticks, 4);

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         set_in(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
